// File: rtl/binary_to_bcd_if.sv
// Conversion bus for binary_to_bcd: binary operand in, packed BCD and overflow out.
// Optional BINARY_TO_BCD_VALID_EN adds the in_valid/out_valid qualifiers.
interface binary_to_bcd_if #(
    parameter int unsigned BIN_W      = 5,
    parameter int unsigned BCD_DIGITS = 2
);
    logic [BIN_W-1:0]        binary_input;
    logic [4*BCD_DIGITS-1:0] bcd_output;
    logic                    overflow;
`ifdef BINARY_TO_BCD_VALID_EN
    logic                    in_valid;
    logic                    out_valid;

    modport master (
        output binary_input,
        output in_valid,
        input  bcd_output,
        input  overflow,
        input  out_valid
    );

    modport slave (
        input  binary_input,
        input  in_valid,
        output bcd_output,
        output overflow,
        output out_valid
    );
`else
    modport master (
        output binary_input,
        input  bcd_output,
        input  overflow
    );

    modport slave (
        input  binary_input,
        output bcd_output,
        output overflow
    );
`endif
endinterface

// File: rtl/binary_to_bcd.sv
// Registered binary-to-packed-BCD converter using an unrolled double-dabble network.
// Define BINARY_TO_BCD_VALID_EN to load only on in_valid and to produce out_valid.
module binary_to_bcd #(
    parameter int unsigned BIN_W      = 5,
    parameter int unsigned BCD_DIGITS = 2
) (
    input logic           clk,
    input logic           rst_n,
    binary_to_bcd_if.slave bus
);

    if (BIN_W < 1 || BCD_DIGITS < 1) begin : g_param_check
        $error("binary_to_bcd: BIN_W and BCD_DIGITS must both be at least 1");
    end

    // Decimal digits in 2^BIN_W-1 is floor(BIN_W*log10(2))+1.
    localparam int unsigned IN_DIGITS  = (BIN_W * 30103) / 100000 + 1;
    localparam int unsigned SCR_DIGITS = (IN_DIGITS > BCD_DIGITS) ? IN_DIGITS : BCD_DIGITS;
    localparam int unsigned SCR_W      = 4 * SCR_DIGITS;
    localparam int unsigned OUT_W      = 4 * BCD_DIGITS;

    logic [SCR_W-1:0] scratch;
    logic             ovf_d;
    logic [OUT_W-1:0] bcd_q;
    logic             ovf_q;

    always_comb begin
        scratch = '0;
        for (int i = int'(BIN_W) - 1; i >= 0; i--) begin
            for (int d = 0; d < int'(SCR_DIGITS); d++) begin
                if (scratch[4*d +: 4] >= 4'd5) begin
                    scratch[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
                end
            end
            scratch = {scratch[SCR_W-2:0], bus.binary_input[i]};
        end
    end

    // Any nonzero digit beyond the output field means the value does not fit.
    if (SCR_DIGITS > BCD_DIGITS) begin : g_ovf
        assign ovf_d = |scratch[SCR_W-1:OUT_W];
    end else begin : g_no_ovf
        assign ovf_d = 1'b0;
    end

`ifdef BINARY_TO_BCD_VALID_EN
    logic valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                bcd_q <= scratch[OUT_W-1:0];
                ovf_q <= ovf_d;
            end
        end
    end

    assign bus.out_valid = valid_q;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            bcd_q <= scratch[OUT_W-1:0];
            ovf_q <= ovf_d;
        end
    end
`endif

    assign bus.bcd_output = bcd_q;
    assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_binary_to_bcd.sv
// Bench for binary_to_bcd: a 5-bit and a 7-bit instance checked every cycle against
// an arithmetic model, plus directed vectors with literal expectations.
`timescale 1ns / 1ps
module tb_binary_to_bcd;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    binary_to_bcd_if #(.BIN_W(5), .BCD_DIGITS(2)) bus_a ();
    binary_to_bcd_if #(.BIN_W(7), .BCD_DIGITS(2)) bus_b ();

    binary_to_bcd #(.BIN_W(5), .BCD_DIGITS(2)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    binary_to_bcd #(.BIN_W(7), .BCD_DIGITS(2)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Two-digit decimal rendering of v modulo 100.
    function automatic logic [7:0] ref_bcd(input int unsigned v);
        logic [7:0] r;
        r[3:0] = 4'((v % 10));
        r[7:4] = 4'(((v / 10) % 10));
        return r;
    endfunction

    logic [7:0] exp_a = 8'h00;
    logic       exp_ovf_a = 1'b0;
    logic [7:0] exp_b = 8'h00;
    logic       exp_ovf_b = 1'b0;
`ifdef BINARY_TO_BCD_VALID_EN
    logic       exp_vld_a = 1'b0;
    logic       exp_vld_b = 1'b0;
`endif

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_a = 8'h00; exp_ovf_a = 1'b0;
            exp_b = 8'h00; exp_ovf_b = 1'b0;
`ifdef BINARY_TO_BCD_VALID_EN
            exp_vld_a = 1'b0; exp_vld_b = 1'b0;
`endif
        end else begin
`ifdef BINARY_TO_BCD_VALID_EN
            exp_vld_a = bus_a.in_valid;
            exp_vld_b = bus_b.in_valid;
            if (bus_a.in_valid) begin
`else
            begin
`endif
                exp_a     = ref_bcd(int'(bus_a.binary_input));
                exp_ovf_a = int'(bus_a.binary_input) > 99;
            end
`ifdef BINARY_TO_BCD_VALID_EN
            if (bus_b.in_valid) begin
`else
            begin
`endif
                exp_b     = ref_bcd(int'(bus_b.binary_input));
                exp_ovf_b = int'(bus_b.binary_input) > 99;
            end
        end
    end

    always @(negedge clk) begin
        chk("a_bcd", 32'(bus_a.bcd_output), 32'(exp_a));
        chk("a_ovf", 32'(bus_a.overflow), 32'(exp_ovf_a));
        chk("a_nibble_range", 32'(bus_a.bcd_output[3:0] <= 4'd9 && bus_a.bcd_output[7:4] <= 4'd9),
            32'd1);
        chk("b_bcd", 32'(bus_b.bcd_output), 32'(exp_b));
        chk("b_ovf", 32'(bus_b.overflow), 32'(exp_ovf_b));
        chk("b_nibble_range", 32'(bus_b.bcd_output[3:0] <= 4'd9 && bus_b.bcd_output[7:4] <= 4'd9),
            32'd1);
`ifdef BINARY_TO_BCD_VALID_EN
        chk("a_out_valid", 32'(bus_a.out_valid), 32'(exp_vld_a));
        chk("b_out_valid", 32'(bus_b.out_valid), 32'(exp_vld_b));
`endif
    end

    // Called at posedge+1: drive at +2, then check literal results after the next edge.
    task automatic drive_check(input int unsigned va, input int unsigned vb,
                               input logic [7:0] ea, input logic [7:0] eb, input logic eob);
        #1;
        bus_a.binary_input = 5'(va);
        bus_b.binary_input = 7'(vb);
        @(posedge clk);
        #1;
        chk($sformatf("lit_a_%0d", va), 32'(bus_a.bcd_output), 32'(ea));
        chk($sformatf("lit_a_ovf_%0d", va), 32'(bus_a.overflow), 32'd0);
        chk($sformatf("lit_b_%0d", vb), 32'(bus_b.bcd_output), 32'(eb));
        chk($sformatf("lit_b_ovf_%0d", vb), 32'(bus_b.overflow), 32'(eob));
    endtask

    int unsigned va_tab[6] = '{0, 3, 9, 10, 19, 20};
    logic [7:0]  ea_tab[6] = '{8'h00, 8'h03, 8'h09, 8'h10, 8'h19, 8'h20};
    int unsigned vb_tab[6] = '{99, 100, 127, 9, 10, 123};
    logic [7:0]  eb_tab[6] = '{8'h99, 8'h00, 8'h27, 8'h09, 8'h10, 8'h23};
    logic        ob_tab[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        bus_a.binary_input = 5'd31;
        bus_b.binary_input = 7'd123;
`ifdef BINARY_TO_BCD_VALID_EN
        bus_a.in_valid = 1'b1;
        bus_b.in_valid = 1'b1;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset_a_bcd", 32'(bus_a.bcd_output), 32'h00);
        chk("reset_a_ovf", 32'(bus_a.overflow), 32'd0);
        chk("reset_b_bcd", 32'(bus_b.bcd_output), 32'h00);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("first_a_31", 32'(bus_a.bcd_output), 32'h31);
        chk("first_b_123", 32'(bus_b.bcd_output), 32'h23);
        chk("first_b_123_ovf", 32'(bus_b.overflow), 32'd1);

        for (int i = 0; i < 6; i++) begin
            drive_check(va_tab[i], vb_tab[i], ea_tab[i], eb_tab[i], ob_tab[i]);
        end

        // Back-to-back inputs, one per cycle; the per-cycle compare covers the sweep.
        for (int v = 0; v < 128; v++) begin
            #1;
            bus_a.binary_input = 5'(v % 32);
            bus_b.binary_input = 7'(v);
            @(posedge clk);
            #1;
        end

        // Reset in the middle of a cycle drops the in-flight sample.
        #1 bus_a.binary_input = 5'd17;
        bus_b.binary_input = 7'd117;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset_a_bcd", 32'(bus_a.bcd_output), 32'h00);
        chk("midreset_b_bcd", 32'(bus_b.bcd_output), 32'h00);
        chk("midreset_b_ovf", 32'(bus_b.overflow), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("after_reset_a_17", 32'(bus_a.bcd_output), 32'h17);
        chk("after_reset_b_117", 32'(bus_b.bcd_output), 32'h17);
        chk("after_reset_b_ovf", 32'(bus_b.overflow), 32'd1);

`ifdef BINARY_TO_BCD_VALID_EN
        #1 bus_a.binary_input = 5'd25;
        bus_a.in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("valid_a_25", 32'(bus_a.bcd_output), 32'h25);
        chk("valid_a_out_valid_1", 32'(bus_a.out_valid), 32'd1);
        #1 bus_a.binary_input = 5'd4;
        bus_a.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("hold_a_25", 32'(bus_a.bcd_output), 32'h25);
        chk("hold_a_out_valid_0", 32'(bus_a.out_valid), 32'd0);
        #1 bus_a.in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("reload_a_4", 32'(bus_a.bcd_output), 32'h04);
`endif

        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
